msg_scroller: RTL

- Column-feed stage directly upstream of the 5x7 LED matrix driver.
- Holds a short text message in a small character buffer and looks up each glyph in a 5x7 font.
- Presents one 7-bit column (prox_col) per clk_6hz edge, so the driver's row shift registers scroll the text right-to-left.
- Adds inter-character gaps and a blank tail, and can loop the message.

---
 rtl/msg_pkg.sv | 18 +
 rtl/font_5x7.sv | 68 ++++++
 rtl/msg_scroller.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/msg_pkg.sv
// Shared types and constants for the scrolling message column feed.
package msg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCROLL,
        ST_GAP,
        ST_TAIL
    } state_e;

    localparam logic [5:0] CH_BLANK = 6'd0;
    localparam logic [5:0] CH_A     = 6'd1;
    localparam logic [5:0] CH_0     = 6'd27;

    localparam int unsigned GLYPH_W = 5;
    localparam int unsigned GLYPH_H = 7;

endpackage

// File: rtl/font_5x7.sv
// Combinational 5x7 glyph ROM: one 7-bit column per (code, col), bit 6 = top row.
module font_5x7
    import msg_pkg::*;
(
    input  logic [5:0] code,
    input  logic [2:0] col,
    output logic [6:0] col_bits
);

    // Glyph packed as {col0, col1, col2, col3, col4}; unknown codes render blank.
    logic [GLYPH_W*GLYPH_H-1:0] glyph_c;

    always_comb begin
        glyph_c = '0;
        case (code)
            CH_A:  glyph_c = {7'b0111111, 7'b1001000, 7'b1001000, 7'b1001000, 7'b0111111};
            6'd2:  glyph_c = {7'b1111111, 7'b1001001, 7'b1001001, 7'b1001001, 7'b0110110};
            6'd3:  glyph_c = {7'b0111110, 7'b1000001, 7'b1000001, 7'b1000001, 7'b0100010};
            6'd4:  glyph_c = {7'b1111111, 7'b1000001, 7'b1000001, 7'b1000001, 7'b0111110};
            6'd5:  glyph_c = {7'b1111111, 7'b1001001, 7'b1001001, 7'b1001001, 7'b1000001};
            6'd6:  glyph_c = {7'b1111111, 7'b1001000, 7'b1001000, 7'b1001000, 7'b1000000};
            6'd7:  glyph_c = {7'b0111110, 7'b1000001, 7'b1001001, 7'b1001001, 7'b0101111};
            6'd8:  glyph_c = {7'b1111111, 7'b0001000, 7'b0001000, 7'b0001000, 7'b1111111};
            6'd9:  glyph_c = {7'b0000000, 7'b1000001, 7'b1111111, 7'b1000001, 7'b0000000};
            6'd10: glyph_c = {7'b0000010, 7'b0000001, 7'b1000001, 7'b1111110, 7'b1000000};
            6'd11: glyph_c = {7'b1111111, 7'b0001000, 7'b0010100, 7'b0100010, 7'b1000001};
            6'd12: glyph_c = {7'b1111111, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001};
            6'd13: glyph_c = {7'b1111111, 7'b0100000, 7'b0011000, 7'b0100000, 7'b1111111};
            6'd14: glyph_c = {7'b1111111, 7'b0010000, 7'b0001000, 7'b0000100, 7'b1111111};
            6'd15: glyph_c = {7'b0111110, 7'b1000001, 7'b1000001, 7'b1000001, 7'b0111110};
            6'd16: glyph_c = {7'b1111111, 7'b1001000, 7'b1001000, 7'b1001000, 7'b0110000};
            6'd17: glyph_c = {7'b0111110, 7'b1000001, 7'b1000101, 7'b1000010, 7'b0111001};
            6'd18: glyph_c = {7'b1111111, 7'b1001000, 7'b1001100, 7'b1001010, 7'b0110001};
            6'd19: glyph_c = {7'b0110001, 7'b1001001, 7'b1001001, 7'b1001001, 7'b1000110};
            6'd20: glyph_c = {7'b1000000, 7'b1000000, 7'b1111111, 7'b1000000, 7'b1000000};
            6'd21: glyph_c = {7'b1111110, 7'b0000001, 7'b0000001, 7'b0000001, 7'b1111110};
            6'd22: glyph_c = {7'b1111100, 7'b0000010, 7'b0000001, 7'b0000010, 7'b1111100};
            6'd23: glyph_c = {7'b1111110, 7'b0000001, 7'b0001110, 7'b0000001, 7'b1111110};
            6'd24: glyph_c = {7'b1100011, 7'b0010100, 7'b0001000, 7'b0010100, 7'b1100011};
            6'd25: glyph_c = {7'b1100000, 7'b0010000, 7'b0001111, 7'b0010000, 7'b1100000};
            6'd26: glyph_c = {7'b1000011, 7'b1000101, 7'b1001001, 7'b1010001, 7'b1100001};
            CH_0:  glyph_c = {7'b0111110, 7'b1000101, 7'b1001001, 7'b1010001, 7'b0111110};
            6'd28: glyph_c = {7'b0000000, 7'b0100001, 7'b1111111, 7'b0000001, 7'b0000000};
            6'd29: glyph_c = {7'b0100001, 7'b1000011, 7'b1000101, 7'b1001001, 7'b0110001};
            6'd30: glyph_c = {7'b1000010, 7'b1000001, 7'b1010001, 7'b1101001, 7'b1000110};
            6'd31: glyph_c = {7'b0001100, 7'b0010100, 7'b0100100, 7'b1111111, 7'b0000100};
            6'd32: glyph_c = {7'b1110010, 7'b1010001, 7'b1010001, 7'b1010001, 7'b1001110};
            6'd33: glyph_c = {7'b0011110, 7'b0101001, 7'b1001001, 7'b1001001, 7'b0000110};
            6'd34: glyph_c = {7'b1000000, 7'b1000111, 7'b1001000, 7'b1010000, 7'b1100000};
            6'd35: glyph_c = {7'b0110110, 7'b1001001, 7'b1001001, 7'b1001001, 7'b0110110};
            6'd36: glyph_c = {7'b0110000, 7'b1001001, 7'b1001001, 7'b1001010, 7'b0111100};
            default: glyph_c = '0;
        endcase
    end

    always_comb begin
        col_bits = '0;
        case (col)
            3'd0: col_bits = glyph_c[34:28];
            3'd1: col_bits = glyph_c[27:21];
            3'd2: col_bits = glyph_c[20:14];
            3'd3: col_bits = glyph_c[13:7];
            3'd4: col_bits = glyph_c[6:0];
            default: col_bits = '0;
        endcase
    end

endmodule

// File: rtl/msg_scroller.sv
// Message buffer plus scroll sequencer feeding one glyph column per clk_6hz edge
// to the LED matrix driver, with inter-character gaps, blank tail and optional loop.
module msg_scroller
    import msg_pkg::*;
#(
    parameter int unsigned MAX_CHARS = 16,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned GAP_COLS  = 1,
    parameter int unsigned TAIL_COLS = 5
) (
    input  logic              clk_6hz,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [5:0]        wr_char,
    input  logic [ADDR_W:0]   msg_len,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [6:0]        prox_col,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned COL_W = 3;
    localparam int unsigned CNT_W = 8;

    logic [5:0]        mem_q [MAX_CHARS];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] char_idx_q, char_idx_d;
    logic [COL_W-1:0]  col_idx_q, col_idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [6:0]        prox_col_q, prox_col_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [5:0]        rd_char_c;
    logic [6:0]        font_bits_c;
    logic              len_ok_c;
    logic              more_chars_c;

    // Buffer is not reset; writes land in every state.
    always_ff @(posedge clk_6hz) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_char;
        end
    end

    // Look up the column that will be presented after this edge.
    assign rd_char_c = mem_q[char_idx_d];

    font_5x7 u_font (
        .code     (rd_char_c),
        .col      (col_idx_d),
        .col_bits (font_bits_c)
    );

    assign len_ok_c     = (msg_len != '0) && (msg_len <= LEN_W'(MAX_CHARS));
    assign more_chars_c = (LEN_W'(char_idx_q) + LEN_W'(1)) < len_q;

    always_comb begin
        state_d    = state_q;
        char_idx_d = char_idx_q;
        col_idx_d  = col_idx_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        done_d     = 1'b0;

        if (stop) begin
            state_d    = ST_IDLE;
            char_idx_d = '0;
            col_idx_d  = '0;
            cnt_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && len_ok_c) begin
                        state_d    = ST_SCROLL;
                        len_d      = msg_len;
                        char_idx_d = '0;
                        col_idx_d  = '0;
                    end
                end
                ST_SCROLL: begin
                    if (col_idx_q == COL_W'(GLYPH_W - 1)) begin
                        state_d = ST_GAP;
                        cnt_d   = '0;
                    end else begin
                        col_idx_d = col_idx_q + COL_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CNT_W'(GAP_COLS - 1)) begin
                        if (more_chars_c) begin
                            state_d    = ST_SCROLL;
                            char_idx_d = char_idx_q + ADDR_W'(1);
                            col_idx_d  = '0;
                        end else begin
                            state_d = ST_TAIL;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_TAIL: begin
                    if (cnt_q == CNT_W'(TAIL_COLS - 1)) begin
                        if (loop) begin
                            state_d    = ST_SCROLL;
                            char_idx_d = '0;
                            col_idx_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign prox_col_d = (state_d == ST_SCROLL) ? font_bits_c : 7'd0;
    assign busy_d     = (state_d != ST_IDLE);

    always_ff @(posedge clk_6hz or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            char_idx_q <= '0;
            col_idx_q  <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            prox_col_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            char_idx_q <= char_idx_d;
            col_idx_q  <= col_idx_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            prox_col_q <= prox_col_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign prox_col = prox_col_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
